// File: rtl/pong16_status.sv
// pong16 read-side status block. It captures game events and a per-frame ball
// snapshot, and returns them on data-memory reads. Holds sticky flags, scores,
// a frame counter and the interrupt request.
module pong16_status #(
  parameter logic [7:0]  PSTAT_ADDR   = 8'hE3,
  parameter logic [7:0]  PSCORE0_ADDR = 8'hE4,
  parameter logic [7:0]  PSCORE1_ADDR = 8'hE5,
  parameter logic [7:0]  PBALLX_ADDR  = 8'hE6,
  parameter logic [7:0]  PBALLY_ADDR  = 8'hE7,
  parameter logic [7:0]  PFRAME_ADDR  = 8'hE8,
  parameter logic [7:0]  PIEN_ADDR    = 8'hE9,
  parameter int unsigned MAX_SCORE    = 99
) (
  input  logic       sys_clk,
  input  logic       rst_clk,
  input  logic       dm_sel,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  input  logic       frame_lvl,
  input  logic [8:0] ball_x,
  input  logic [7:0] ball_y,
  input  logic       score0_evt,
  input  logic       score1_evt,
  input  logic       hit_evt,
  input  logic       game_rst,
  output logic       irq
);

  localparam logic [7:0] MaxScore = 8'(MAX_SCORE);

  logic [3:0] flags_q, flags_d;
  logic [7:0] score0_q, score0_d;
  logic [7:0] score1_q, score1_d;
  logic [7:0] frame_q, frame_d;
  logic [8:0] ballx_q;
  logic [7:0] bally_q;
  logic [3:0] pien_q;
  logic       frame_lvl_q;
  logic       frame_det;
  logic       irq_d;

  logic rd_stat;
  logic wr_score0, wr_score1, wr_frame, wr_pien;

  // Bus decode for the side-effecting accesses.
  always_comb begin
    rd_stat   = dm_sel & ramre & (ramadr == PSTAT_ADDR);
    wr_score0 = dm_sel & ramwe & (ramadr == PSCORE0_ADDR);
    wr_score1 = dm_sel & ramwe & (ramadr == PSCORE1_ADDR);
    wr_frame  = dm_sel & ramwe & (ramadr == PFRAME_ADDR);
    wr_pien   = dm_sel & ramwe & (ramadr == PIEN_ADDR);
    frame_det = frame_lvl & ~frame_lvl_q;
  end

  // Score update: game reset, then bus load (clamped), then saturating increment.
  function automatic logic [7:0] score_next(input logic [7:0] cur, input logic clr,
                                            input logic wr, input logic [7:0] din,
                                            input logic evt);
    if (clr) begin
      score_next = 8'd0;
    end else if (wr) begin
      score_next = (din > MaxScore) ? MaxScore : din;
    end else if (evt && (cur < MaxScore)) begin
      score_next = cur + 8'd1;
    end else begin
      score_next = cur;
    end
  endfunction

  // Next-state for flags, scores, frame counter and interrupt request.
  always_comb begin
    // A new event in the same cycle as the clearing read keeps the flag set.
    flags_d  = (flags_q & ~{4{rd_stat}}) |
               {frame_det, hit_evt, score1_evt, score0_evt};
    score0_d = score_next(score0_q, game_rst, wr_score0, dbus_in, score0_evt);
    score1_d = score_next(score1_q, game_rst, wr_score1, dbus_in, score1_evt);
    if (wr_frame) begin
      frame_d = dbus_in;
    end else if (frame_det) begin
      frame_d = frame_q + 8'd1;
    end else begin
      frame_d = frame_q;
    end
    irq_d = |(flags_d & pien_q);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge sys_clk or posedge rst_clk) begin
    if (rst_clk) begin
      flags_q     <= '0;
      score0_q    <= '0;
      score1_q    <= '0;
      frame_q     <= '0;
      ballx_q     <= '0;
      bally_q     <= '0;
      pien_q      <= '0;
      frame_lvl_q <= 1'b0;
      irq         <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      frame_q     <= frame_d;
      frame_lvl_q <= frame_lvl;
      irq         <= irq_d;
      if (wr_pien) begin
        pien_q <= dbus_in[3:0];
      end
      // Snapshot only at frame start so X, Y and X[8] stay coherent.
      if (frame_det) begin
        ballx_q <= ball_x;
        bally_q <= ball_y;
      end
    end
  end

  // Zero-latency read mux; drives the bus only for this block's addresses.
  always_comb begin
    dbus_out  = 8'd0;
    io_out_en = 1'b0;
    if (dm_sel && ramre) begin
      io_out_en = 1'b1;
      case (ramadr)
        PSTAT_ADDR:   dbus_out = {ballx_q[8], 3'b000, flags_q};
        PSCORE0_ADDR: dbus_out = score0_q;
        PSCORE1_ADDR: dbus_out = score1_q;
        PBALLX_ADDR:  dbus_out = ballx_q[7:0];
        PBALLY_ADDR:  dbus_out = bally_q;
        PFRAME_ADDR:  dbus_out = frame_q;
        PIEN_ADDR:    dbus_out = {4'b0000, pien_q};
        default:      io_out_en = 1'b0;
      endcase
    end
  end

endmodule
